// File: rtl/debounce_multi.sv
// Multi-channel button conditioner: synchroniser, stable-window debounce,
// press/release pulses and long-press detection with optional auto-repeat.
module debounce_multi #(
    parameter int             NCH          = 4,
    parameter int             PRESCALE     = 1000,
    parameter int             DB_TICKS     = 20,
    parameter int             HOLD_TICKS   = 1000,
    parameter int             REPEAT_TICKS = 200,
    parameter int             CNT_W        = 12,
    parameter logic [NCH-1:0] INVERT       = '0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [NCH-1:0] i_buttons,
    output logic [NCH-1:0] o_state,
    output logic [NCH-1:0] o_press,
    output logic [NCH-1:0] o_release,
    output logic [NCH-1:0] o_hold,
    output logic           o_any_change
);

    localparam int               PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
    localparam bit               REPEAT_EN = (REPEAT_TICKS != 0);

    logic [PRE_W-1:0] r_pre_cnt;
    logic             w_tick;

    logic [NCH-1:0]   r_sync1;
    logic [NCH-1:0]   r_sync2;
    logic [NCH-1:0]   w_s;

    logic [NCH-1:0]   r_state;
    logic [NCH-1:0]   r_press;
    logic [NCH-1:0]   r_release;
    logic [NCH-1:0]   r_hold;
    logic [NCH-1:0]   r_fired;
    logic [CNT_W-1:0] r_db_cnt   [NCH];
    logic [CNT_W-1:0] r_hold_cnt [NCH];

    assign w_tick = (r_pre_cnt == PRE_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + PRE_W'(1);
        end
    end

    // Loading INVERT on reset makes the corrected level read as released.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= INVERT;
            r_sync2 <= INVERT;
        end else begin
            r_sync1 <= i_buttons;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2 ^ INVERT;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_hold    <= '0;
            r_fired   <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_db_cnt[i]   <= '0;
                r_hold_cnt[i] <= '0;
            end
        end else begin
            r_press   <= '0;
            r_release <= '0;
            r_hold    <= '0;
            for (int i = 0; i < NCH; i++) begin
                // Any return to the committed level restarts the window.
                if (w_s[i] == r_state[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_tick) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_state[i]   <= w_s[i];
                        r_db_cnt[i]  <= '0;
                        r_press[i]   <= w_s[i];
                        r_release[i] <= ~w_s[i];
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
                    end
                end

                if (!r_state[i]) begin
                    r_hold_cnt[i] <= '0;
                    r_fired[i]    <= 1'b0;
                end else if (w_tick) begin
                    if (!r_fired[i]) begin
                        if (r_hold_cnt[i] == HOLD_LAST) begin
                            r_hold[i]     <= 1'b1;
                            r_fired[i]    <= 1'b1;
                            r_hold_cnt[i] <= '0;
                        end else begin
                            r_hold_cnt[i] <= r_hold_cnt[i] + CNT_W'(1);
                        end
                    end else if (REPEAT_EN) begin
                        if (r_hold_cnt[i] == REP_LAST) begin
                            r_hold[i]     <= 1'b1;
                            r_hold_cnt[i] <= '0;
                        end else begin
                            r_hold_cnt[i] <= r_hold_cnt[i] + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign o_state      = r_state;
    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_hold       = r_hold;
    assign o_any_change = |(r_press | r_release);

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: three configurations driven from shared pins,
// directed timing scenarios plus a random run against a behavioural model.
module tb_debounce_multi;

    localparam int         DBT = 4;
    localparam int         HT  = 10;
    localparam logic [3:0] INV = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = INV;

    logic [3:0] st [3];
    logic [3:0] pr [3];
    logic [3:0] rl [3];
    logic [3:0] hd [3];
    logic       anyc [3];

    int errors = 0;
    int checks = 0;

    // dut 0: repeat on, dut 1: no repeat, dut 2: prescale 4
    int cfg_p [3] = '{1, 1, 4};
    int cfg_r [3] = '{5, 0, 5};

    logic [3:0] m_s1 [3];
    logic [3:0] m_s2 [3];
    logic [3:0] m_st [3];
    logic [3:0] e_pr [3];
    logic [3:0] e_rl [3];
    logic [3:0] e_hd [3];
    int         m_n  [3];
    int         m_db [3][4];
    int         m_hi [3][4];

    always #5 clk = ~clk;

    debounce_multi #(.NCH(4), .PRESCALE(1), .DB_TICKS(DBT), .HOLD_TICKS(HT),
                     .REPEAT_TICKS(5), .CNT_W(12), .INVERT(INV)) u_a (
        .i_clk(clk), .i_rst(rst), .i_buttons(btn), .o_state(st[0]), .o_press(pr[0]),
        .o_release(rl[0]), .o_hold(hd[0]), .o_any_change(anyc[0]));

    debounce_multi #(.NCH(4), .PRESCALE(1), .DB_TICKS(DBT), .HOLD_TICKS(HT),
                     .REPEAT_TICKS(0), .CNT_W(12), .INVERT(INV)) u_b (
        .i_clk(clk), .i_rst(rst), .i_buttons(btn), .o_state(st[1]), .o_press(pr[1]),
        .o_release(rl[1]), .o_hold(hd[1]), .o_any_change(anyc[1]));

    debounce_multi #(.NCH(4), .PRESCALE(4), .DB_TICKS(DBT), .HOLD_TICKS(HT),
                     .REPEAT_TICKS(5), .CNT_W(12), .INVERT(INV)) u_c (
        .i_clk(clk), .i_rst(rst), .i_buttons(btn), .o_state(st[2]), .o_press(pr[2]),
        .o_release(rl[2]), .o_hold(hd[2]), .o_any_change(anyc[2]));

    // Behavioural model: ticks from elapsed cycles since reset, hold pulses
    // from total ticks spent pressed.
    task automatic model_step(input int d);
        logic       tick;
        logic [3:0] s, nst;
        logic       old;
        if (rst) begin
            m_s1[d] = INV; m_s2[d] = INV; m_st[d] = '0;
            e_pr[d] = '0;  e_rl[d] = '0;  e_hd[d] = '0;
            m_n[d]  = 0;
            for (int c = 0; c < 4; c++) begin
                m_db[d][c] = 0;
                m_hi[d][c] = 0;
            end
        end else begin
            tick = ((m_n[d] % cfg_p[d]) == cfg_p[d] - 1);
            m_n[d]++;
            s = m_s2[d] ^ INV;
            nst = m_st[d];
            e_pr[d] = '0; e_rl[d] = '0; e_hd[d] = '0;
            for (int c = 0; c < 4; c++) begin
                old = m_st[d][c];
                if (!old) m_hi[d][c] = 0;
                else if (tick) begin
                    m_hi[d][c]++;
                    if (m_hi[d][c] == HT ||
                        (cfg_r[d] > 0 && m_hi[d][c] > HT && (m_hi[d][c] - HT) % cfg_r[d] == 0))
                        e_hd[d][c] = 1'b1;
                end
                if (s[c] == old) m_db[d][c] = 0;
                else if (tick) begin
                    m_db[d][c]++;
                    if (m_db[d][c] == DBT) begin
                        nst[c] = s[c];
                        m_db[d][c] = 0;
                        e_pr[d][c] = s[c];
                        e_rl[d][c] = ~s[c];
                    end
                end
            end
            m_st[d] = nst;
            m_s2[d] = m_s1[d];
            m_s1[d] = btn;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_step(d);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        btn = INV;
        rst = 1'b1;
        advance();
        advance();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({st[d], pr[d], rl[d], hd[d], anyc[d]} !== 17'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got %h required 0", d,
                         {st[d], pr[d], rl[d], hd[d], anyc[d]});
            end
        end
        rst = 1'b0;
        bad = 0;
        for (int e = 1; e <= 12; e++) begin
            advance();
            for (int d = 0; d < 3; d++)
                if ({st[d], pr[d], rl[d], hd[d], anyc[d]} !== 17'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL post_reset_quiet nonzero_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_step();
        int a_rise = -1, c_rise = -1, a_press = 0, a_press_e = -1, a_any = 0, a_other = 0;
        btn = INV;
        do_reset();
        btn[0] = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            advance();
            if (st[0][0] && a_rise < 0) a_rise = e;
            if (st[2][0] && c_rise < 0) c_rise = e;
            if (pr[0][0]) begin a_press++; a_press_e = e; end
            if (anyc[0]) a_any++;
            if (pr[0][3:1] != 0 || rl[0] != 0) a_other++;
        end
        checks++;
        if (a_rise !== 6) begin errors++; $display("FAIL step_rise_edge got %0d required 6", a_rise); end
        checks++;
        if (a_press !== 1 || a_press_e !== 6) begin
            errors++; $display("FAIL step_press got count=%0d edge=%0d required 1 at 6", a_press, a_press_e);
        end
        checks++;
        if (a_any !== 1) begin errors++; $display("FAIL step_any_change got %0d required 1", a_any); end
        checks++;
        if (a_other !== 0) begin errors++; $display("FAIL step_other_quiet got %0d required 0", a_other); end
        checks++;
        if (c_rise < 15 || c_rise > 18) begin
            errors++; $display("FAIL prescale_rise_edge got %0d required 15..18", c_rise);
        end
    endtask

    task automatic test_bounce();
        int presses = 0, releases = 0, press_e = -1;
        btn = INV;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            btn[1] = (k % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                advance();
                presses += pr[0][1];
                releases += rl[0][1];
            end
        end
        btn[1] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            advance();
            if (pr[0][1]) begin presses++; press_e = e; end
            releases += rl[0][1];
        end
        checks++;
        if (presses !== 1 || press_e !== 6) begin
            errors++; $display("FAIL bounce_press got count=%0d edge=%0d required 1 at 6", presses, press_e);
        end
        checks++;
        if (releases !== 0) begin errors++; $display("FAIL bounce_release got %0d required 0", releases); end
    endtask

    task automatic test_glitch();
        int a_ev = 0, c_ev = 0;
        btn = INV;
        do_reset();
        btn[2] = 1'b1;
        for (int e = 0; e < 3; e++) begin
            advance();
            a_ev += int'(st[0] != 0) + int'(pr[0] != 0) + int'(rl[0] != 0) + int'(hd[0] != 0) + int'(anyc[0]);
        end
        btn[2] = 1'b0;
        for (int e = 0; e < 15; e++) begin
            advance();
            a_ev += int'(st[0] != 0) + int'(pr[0] != 0) + int'(rl[0] != 0) + int'(hd[0] != 0) + int'(anyc[0]);
        end
        checks++;
        if (a_ev !== 0) begin errors++; $display("FAIL glitch3_rejected got events=%0d required 0", a_ev); end
        do_reset();
        btn[2] = 1'b1;
        for (int e = 0; e < 40; e++) begin
            if (e == 10) btn[2] = 1'b0;
            advance();
            c_ev += int'(st[2] != 0) + int'(pr[2] != 0) + int'(rl[2] != 0) + int'(anyc[2]);
        end
        checks++;
        if (c_ev !== 0) begin errors++; $display("FAIL glitch10_prescale got events=%0d required 0", c_ev); end
    endtask

    task automatic test_hold();
        int a_hold[$];
        int b_holds = 0, b_hold_e = -1, rel_e = -1, rels = 0, late_holds = 0;
        btn = INV;
        do_reset();
        btn[0] = 1'b1;
        for (int e = 1; e <= 80; e++) begin
            if (e == 47) btn[0] = 1'b0;
            advance();
            if (hd[0][0]) begin
                if (rel_e >= 0) late_holds++;
                else a_hold.push_back(e);
            end
            if (rl[0][0]) begin rels++; rel_e = e; end
            if (hd[1][0]) begin b_holds++; b_hold_e = e; end
        end
        checks++;
        if (a_hold.size() !== 8 || a_hold[0] !== 16 || a_hold[1] !== 21 || a_hold[2] !== 26 || a_hold[7] !== 51) begin
            errors++;
            $display("FAIL hold_repeat got n=%0d first=%0d,%0d,%0d required 8 pulses 16,21,26..51",
                     a_hold.size(), (a_hold.size() > 0) ? a_hold[0] : -1,
                     (a_hold.size() > 1) ? a_hold[1] : -1, (a_hold.size() > 2) ? a_hold[2] : -1);
        end
        checks++;
        if (rels !== 1 || rel_e !== 52) begin
            errors++; $display("FAIL hold_release got count=%0d edge=%0d required 1 at 52", rels, rel_e);
        end
        checks++;
        if (late_holds !== 0) begin errors++; $display("FAIL hold_after_release got %0d required 0", late_holds); end
        checks++;
        if (b_holds !== 1 || b_hold_e !== 16) begin
            errors++; $display("FAIL hold_no_repeat got count=%0d edge=%0d required 1 at 16", b_holds, b_hold_e);
        end
    endtask

    task automatic test_reset_mid();
        int rise = -1, presses = 0, first_pulse = 0;
        btn = INV;
        do_reset();
        btn = 4'b1001;
        for (int e = 0; e < 4; e++) advance();
        rst = 1'b1;
        advance();
        checks++;
        if ({st[0], pr[0], rl[0], hd[0], anyc[0]} !== 17'd0) begin
            errors++; $display("FAIL midreset_outputs got %h required 0", {st[0], pr[0], rl[0], hd[0], anyc[0]});
        end
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            advance();
            if (e == 1) first_pulse = int'(pr[0] != 0) + int'(rl[0] != 0) + int'(hd[0] != 0);
            if (st[0][0] && rise < 0) rise = e;
            presses += pr[0][0];
        end
        checks++;
        if (first_pulse !== 0) begin errors++; $display("FAIL midreset_first_cycle got %0d required 0", first_pulse); end
        checks++;
        if (rise !== 6 || presses !== 1) begin
            errors++; $display("FAIL midreset_recommit got edge=%0d presses=%0d required 6 and 1", rise, presses);
        end
    endtask

    task automatic test_simul();
        logic [3:0] p6, r6;
        logic       any6;
        btn = INV;
        do_reset();
        btn = 4'b0111;
        for (int e = 1; e <= 8; e++) begin
            advance();
            if (e == 6) begin p6 = pr[0]; any6 = anyc[0]; end
        end
        checks++;
        if (p6 !== 4'b1111 || any6 !== 1'b1) begin
            errors++; $display("FAIL simul_press got press=%b any=%b required 1111 1", p6, any6);
        end
        btn = INV;
        for (int e = 1; e <= 8; e++) begin
            advance();
            if (e == 6) begin r6 = rl[0]; p6 = pr[0]; end
        end
        checks++;
        if (r6 !== 4'b1111 || p6 !== 4'b0000) begin
            errors++; $display("FAIL simul_release got release=%b press=%b required 1111 0000", r6, p6);
        end
    endtask

    task automatic test_random();
        int left [4] = '{0, 0, 0, 0};
        int bad = 0;
        btn = INV;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                if (left[c] == 0) begin
                    btn[c] = 1'($urandom_range(0, 1));
                    left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 70);
                end
                left[c]--;
            end
            rst = ($urandom_range(0, 499) == 0);
            advance();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if ({st[d], pr[d], rl[d], hd[d], anyc[d]} !==
                    {m_st[d], e_pr[d], e_rl[d], e_hd[d], |(e_pr[d] | e_rl[d])}) begin
                    errors++;
                    if (bad < 10)
                        $display("FAIL random_model dut%0d cycle %0d got %h required %h", d, cyc,
                                 {st[d], pr[d], rl[d], hd[d], anyc[d]},
                                 {m_st[d], e_pr[d], e_rl[d], e_hd[d], |(e_pr[d] | e_rl[d])});
                    bad++;
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_bounce();
        test_glitch();
        test_hold();
        test_reset_mid();
        test_simul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
